// File: rtl/game_timer.sv
// game_timer: per-difficulty countdown round timer with pause, restart, abort and expiry pulse.
// Define GAME_TIMER_WARN_EN to drive the low-time warn output; otherwise warn is tied low.
module game_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int CNT_W     = 7,
  parameter int LOAD_EASY = 30,
  parameter int LOAD_MED  = 60,
  parameter int LOAD_HARD = 90,
  parameter int WARN_SECS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       difficulty,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [CNT_W-1:0] counter,
  output logic             running,
  output logic             expired,
  output logic             done,
  output logic             warn
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [CNT_W-1:0] cnt_n, load;
  logic exp_n, go, tick;
  if (TICK_DIV < 1) begin : g_bad_div
    $error("game_timer: TICK_DIV must be >= 1");
  end
  if (LOAD_EASY < 1 || LOAD_EASY >= 2**CNT_W || LOAD_MED < 1 || LOAD_MED >= 2**CNT_W ||
      LOAD_HARD < 1 || LOAD_HARD >= 2**CNT_W) begin : g_bad_load
    $error("game_timer: LOAD_* must be in 1 .. 2**CNT_W-1");
  end
  if (WARN_SECS < 0) begin : g_bad_warn
    $error("game_timer: WARN_SECS must be >= 0");
  end
  always_comb begin
    load = difficulty == 2'd1 ? CNT_W'(LOAD_EASY) : difficulty == 2'd2 ? CNT_W'(LOAD_MED) : CNT_W'(LOAD_HARD);
    go = start && difficulty != 2'd0;
    tick = pre == PMAX;
    state_n = state;
    cnt_n = counter;
    pre_n = pre;
    exp_n = 1'b0;
    if (abort) begin
      state_n = IDLE;
      cnt_n = '0;
      pre_n = '0;
    end else if (go) begin
      state_n = RUN;
      cnt_n = load;
      pre_n = '0;
    end else if (state == RUN) begin
      // a tick coinciding with pause is dropped and the prescaler frozen
      if (pause) state_n = PAUSED;
      else begin
        pre_n = tick ? '0 : pre + 1'b1;
        if (tick) begin
          cnt_n = counter - 1'b1;
          state_n = counter == CNT_W'(1) ? DONE : RUN;
          exp_n = counter == CNT_W'(1);
        end
      end
    end else if (state == PAUSED && !pause) state_n = RUN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      counter <= '0;
      pre <= '0;
      expired <= 1'b0;
      running <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      counter <= cnt_n;
      pre <= pre_n;
      expired <= exp_n;
      running <= state_n == RUN;
      done <= state_n == DONE;
    end
  end
`ifdef GAME_TIMER_WARN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) warn <= 1'b0;
    else warn <= (state_n == RUN || state_n == PAUSED) && cnt_n != '0 && int'(cnt_n) <= WARN_SECS;
  end
`else
  assign warn = 1'b0;
`endif
endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Parametrised countdown timer for the guessing game; the next generation of the per-difficulty round timer.
- Loads a per-difficulty second count on start and decrements once per prescaled tick.
- Supports pause, restart and abort, and flags expiry to the game controller.
- Sits between the difficulty-select logic and the game FSM / seven-segment display driver.

Parameters:
- TICK_DIV, 50000000, clk cycles per counter decrement (1 s at 50 MHz); must be >= 1
- CNT_W, 7, width of counter output
- LOAD_EASY, 30, seconds loaded for difficulty 1
- LOAD_MED, 60, seconds loaded for difficulty 2
- LOAD_HARD, 90, seconds loaded for difficulty 3
- WARN_SECS, 10, warning threshold (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- difficulty  in  2  0 = none, 1 = easy, 2 = medium, 3 = hard; sampled only on an accepted start
- start  in  1  single-cycle request to load and run (also restarts)
- pause  in  1  level; holds the countdown while high
- abort  in  1  single-cycle request to return to IDLE
- counter  out  CNT_W  remaining seconds
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse when counter reaches 0
- done  out  1  level, high in DONE
- warn  out  1  low-time warning (optional feature)

Behaviour:
- Reset is asynchronous, active-high, on one clock (clk).
  - Reset values: state IDLE, counter 0, prescaler 0, running 0, expired 0, done 0, warn 0.
  - Reset mid-operation clears everything immediately, with no clock edge required.
- Elaboration checks: each LOAD_* must be >= 1 and < 2**CNT_W; any violation is an elaboration error. There is no silent truncation.
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
- Per-cycle input priority: abort > start > pause > tick.
- IDLE:
  - counter holds 0.
  - start with difficulty != 0: load counter with the LOAD_* value, clear the prescaler, go to RUN on the next edge.
  - start with difficulty == 0: ignored, stay in IDLE.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps to 0. The wrap cycle is a tick; counter decrements on the tick edge.
  - Tick while counter == 1: counter becomes 0, state goes to DONE, and expired=1 for exactly that one following cycle.
  - pause=1: go to PAUSED and freeze the prescaler value. A tick in the same cycle as pause is discarded (no decrement).
  - start (difficulty != 0): reload from the current difficulty, clear the prescaler, stay in RUN.
  - start with difficulty == 0 in RUN: ignored.
  - abort: go to IDLE, counter 0, prescaler 0.
- PAUSED:
  - counter and prescaler are held.
  - pause=0: return to RUN; the prescaler resumes from its held value.
  - start (difficulty != 0): reload and go to RUN, even if pause is still high. Pause is then honoured on the following cycle.
  - abort: go to IDLE.
- DONE:
  - counter 0, done=1.
  - start (difficulty != 0): reload and go to RUN (new round).
  - abort: go to IDLE.
  - Ticks are ignored; counter never wraps below 0.
- Difficulty changes are ignored except on an accepted start.
- running=1 only in RUN; done=1 only in DONE. Neither is asserted in PAUSED.
- TICK_DIV == 1: every RUN cycle is a tick.

Optional Feature:
- Macro: GAME_TIMER_WARN_EN.
- Defined: warn is registered, high when the state is RUN or PAUSED and 1 <= counter <= WARN_SECS; low otherwise, including in DONE.
- Undefined: the warn port still exists and is tied to constant 0, so the interface is identical in both builds; WARN_SECS is unused.

Test Plan:
- TICK_DIV=4, difficulty=1, start pulse -> counter=30, running=1 on the next edge; counter=29 after 4 more cycles; counter=0 after 120 cycles in RUN; expired high for exactly 1 cycle, then done=1, running=0.
- Run to counter=25, hold pause for 20 cycles -> counter stays 25 and running=0. Release pause -> next decrement occurs after the remaining prescaler count (less than 4 cycles), not a full 4.
- start with difficulty=0 in IDLE -> stays IDLE, counter=0. In RUN at counter=12, start with difficulty=3 -> counter=90, prescaler restarted.
- abort and start asserted in the same cycle during RUN -> IDLE, counter=0. In DONE, start with difficulty=2 -> counter=60, RUN.
- Assert reset asynchronously mid-RUN (counter=17) -> counter=0 and all flags 0 before the next clk edge; no expired pulse.
- With GAME_TIMER_WARN_EN and WARN_SECS=10 -> warn rises when counter becomes 10, stays high through 1, is low at 0/DONE, and is high in PAUSED at counter=5. Without the macro -> warn=0 throughout.
